mont_precomp: RTL
=================

# mont_precomp

Front-end stage of the modular exponentiator. It latches a message M, modulus n and exponent e, then converts M into the Montgomery domain: M_bar = M·2^BITLEN mod n and x_bar = 2^BITLEN mod n. It writes both values into the shared operand RAM, finds the index of the most significant set bit of e, and launches `mon_exp`. It then waits for `mon_exp` to finish and returns the captured answer with a one-cycle done pulse.

## Interface
- BITLEN, 256, operand width
- LOG_BITLEN, 8, log2(BITLEN); width of e_idx
- ABITS, 8, RAM address width
- DBITS, BITLEN, RAM data width
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; sampled only in IDLE
- m  in  BITLEN  message, must be < n
- n  in  BITLEN  modulus, must be odd and > 1
- e  in  BITLEN  exponent, must be non-zero
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when ans is valid
- err  out  1  one-cycle pulse instead of done when inputs are rejected
- ans  out  BITLEN  result, held until the next done
- exp_start  out  1  one-cycle launch pulse to mon_exp
- exp_e  out  BITLEN  latched e, drives mon_exp e
- exp_n  out  BITLEN  latched n, drives mon_exp n
- exp_e_idx  out  LOG_BITLEN  MSB index of the latched e
- exp_stop  in  1  mon_exp stop
- exp_ans  in  BITLEN  mon_exp ans
- pc_wr_en  out  1  RAM write strobe; the top level muxes RAM writes to this block when pc_wr_en is high
- pc_wr_addr  out  ABITS  RAM write address
- pc_wr_data  out  DBITS  RAM write data

## Operation
- **IDLE:** on start, latch m, n and e into internal registers; exp_e and exp_n follow these latches. Go to CHECK.
- **CHECK (1 cycle):**
  - Reject if n[0]==0, n<=1, m>=n or e==0: pulse err, go to IDLE, perform no RAM writes and no exp_start.
  - Otherwise register exp_e_idx = highest set bit of e, initialise x=1 and y=m, clear the step counter, go to REDUCE.
- **REDUCE (exactly BITLEN cycles):**
  - Each cycle: x ← 2x ≥ n ? 2x−n : 2x, and y likewise.
  - Intermediates are BITLEN+1 bits wide; results are always < n.
  - The step counter is LOG_BITLEN+1 bits; leave the state when it reaches BITLEN−1.
- **WR_X:** pc_wr_en=1, addr ADDR_XBAR, data x.
- **WR_M:** pc_wr_en=1, addr ADDR_MBAR, data y.
- **LAUNCH:** exp_start=1 for one cycle, go to WAIT.
- **WAIT:**
  - Rising edge of exp_stop (exp_stop high, previous sample low): capture exp_ans into ans, go to DONE.
  - A level held high from before LAUNCH does not qualify.
- **DONE:** pulse done, go to IDLE.
- **Boundary behaviour:**
  - start while busy is ignored; it is not queued.
  - A start coincident with the DONE cycle is ignored; start must be presented again in IDLE.
  - Reset mid-operation (any state) returns to IDLE immediately, with no further writes and no exp_start.
  - e with only bit 0 set gives exp_e_idx=0.

## Timing
- **Reset values:** state IDLE; busy, done, err, exp_start, pc_wr_en = 0; ans, exp_e, exp_n, exp_e_idx, pc_wr_addr, pc_wr_data = 0.
- **Rejected request:** start to err = 2 cycles (the start edge, then CHECK).
- **Accepted request:** start to exp_start = 1 + 1 + BITLEN + 3 cycles.
- **Write order:** the x_bar write precedes the M_bar write by one cycle; both complete before exp_start.
- **Completion:** done is asserted one cycle after the qualifying exp_stop edge; ans is valid in the same cycle as done.
- **Output hold:** exp_e, exp_n and exp_e_idx stay stable from CHECK until the next accepted start.

## Configuration
- MONT_PRECOMP_CHECK_EN
  - **Defined:** input validation in CHECK as above; err functional.
  - **Undefined:** CHECK performs no rejection and always proceeds to REDUCE; err tied to 0; the caller guarantees valid operands (behaviour with invalid operands is unspecified, but no hang in REDUCE).

## Structure
- **Shared package rsa_pkg:**
  - state encoding localparams
  - ADDR_XBAR = 0 and ADDR_MBAR = 1; mon_exp reads these same addresses
  - OPXX/OPXM/OPX1 op codes, kept alongside
- **Sub-module mod_double:**
  - Combinational: inputs v and n, output (2v ≥ n) ? 2v−n : 2v.
  - Instantiated twice, for x and y.
- The MSB priority encoder is a package function.

## Test plan
- BITLEN=8, n=13, m=5, e=0b1011 → writes addr0=9 and addr1=6, exp_e_idx=3, exp_start at cycle 13 after start; exp_ans=0x2A with an exp_stop pulse → ans=0x2A, done one cycle later.
- n=12 (even) with MONT_PRECOMP_CHECK_EN → err pulse at cycle 2, no pc_wr_en, no exp_start; ans unchanged.
- m=13, n=13 → err; e=0 → err.
- Second start during REDUCE → ignored; only one exp_start and one done; written values unchanged.
- rst_n low in the 4th REDUCE cycle → busy=0 immediately; no writes and no exp_start follow; a fresh start then completes normally.
- exp_stop held high from LAUNCH for 3 cycles → exactly one done; exp_stop high before LAUNCH is not counted.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: state codes, operand RAM map and op codes shared by
// the exponentiator stages, plus the MSB priority encoder.
package rsa_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CHECK  = 3'd1;
  localparam state_t ST_REDUCE = 3'd2;
  localparam state_t ST_WR_X   = 3'd3;
  localparam state_t ST_WR_M   = 3'd4;
  localparam state_t ST_LAUNCH = 3'd5;
  localparam state_t ST_WAIT   = 3'd6;
  localparam state_t ST_DONE   = 3'd7;

  localparam int ADDR_XBAR = 0;
  localparam int ADDR_MBAR = 1;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  // Widest operand the encoder accepts; narrower ones are zero-extended.
  localparam int MSB_W = 1024;

  function automatic logic [15:0] msb_idx(
    input logic [MSB_W-1:0] v
  );
    msb_idx = '0;
    for (int i = 0; i < MSB_W; i++) begin
      if (v[i]) msb_idx = 16'(i);
    end
  endfunction

endpackage

// File: rtl/mont_precomp_if.sv
// mont_precomp_if: request/response, mon_exp launch and
// operand RAM write signals of the precompute stage.
interface mont_precomp_if #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int ABITS      = 8,
  parameter int DBITS      = BITLEN
);
  logic                  start;
  logic [BITLEN-1:0]     m;
  logic [BITLEN-1:0]     n;
  logic [BITLEN-1:0]     e;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BITLEN-1:0]     ans;
  logic                  exp_start;
  logic [BITLEN-1:0]     exp_e;
  logic [BITLEN-1:0]     exp_n;
  logic [LOG_BITLEN-1:0] exp_e_idx;
  logic                  exp_stop;
  logic [BITLEN-1:0]     exp_ans;
  logic                  pc_wr_en;
  logic [ABITS-1:0]      pc_wr_addr;
  logic [DBITS-1:0]      pc_wr_data;

  modport slave (
    input  start, m, n, e,
    input  exp_stop, exp_ans,
    output busy, done, err, ans,
    output exp_start, exp_e, exp_n, exp_e_idx,
    output pc_wr_en, pc_wr_addr, pc_wr_data
  );

  modport master (
    output start, m, n, e,
    output exp_stop, exp_ans,
    input  busy, done, err, ans,
    input  exp_start, exp_e, exp_n, exp_e_idx,
    input  pc_wr_en, pc_wr_addr, pc_wr_data
  );
endinterface

// File: rtl/mod_double.sv
// mod_double: one modular doubling step, (2v >= n) ? 2v-n : 2v,
// with a BITLEN+1 bit intermediate; v < n gives a result < n.
module mod_double #(
  parameter int BITLEN = 256
) (
  input  logic [BITLEN-1:0] v,
  input  logic [BITLEN-1:0] n,
  output logic [BITLEN-1:0] d
);
  logic [BITLEN:0] w_dbl;
  logic            w_ge;

  assign w_dbl = {v, 1'b0};
  assign w_ge  = (w_dbl >= {1'b0, n});
  // The difference is < n, so the low BITLEN bits hold it exactly.
  assign d = w_ge ? (w_dbl[BITLEN-1:0] - n)
                  : w_dbl[BITLEN-1:0];
endmodule

// File: rtl/mont_precomp.sv
// mont_precomp: Montgomery-domain conversion and mon_exp launch.
// Define MONT_PRECOMP_CHECK_EN to reject invalid operands via err.
module mont_precomp
  import rsa_pkg::*;
#(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int ABITS      = 8,
  parameter int DBITS      = BITLEN
) (
  input logic            clk,
  input logic            rst_n,
  mont_precomp_if.slave  bus
);

  localparam logic [LOG_BITLEN:0] CNT_LAST =
    (LOG_BITLEN+1)'(BITLEN-1);

  state_t                r_state;
  logic [BITLEN-1:0]     r_m;
  logic [BITLEN-1:0]     r_n;
  logic [BITLEN-1:0]     r_e;
  logic [BITLEN-1:0]     r_x;
  logic [BITLEN-1:0]     r_y;
  logic [BITLEN-1:0]     r_ans;
  logic [LOG_BITLEN:0]   r_cnt;
  logic [LOG_BITLEN-1:0] r_e_idx;
  logic                  r_err;
  logic                  r_done;
  logic                  r_xs;
  logic                  r_wr;
  logic [ABITS-1:0]      r_waddr;
  logic [DBITS-1:0]      r_wdata;
  logic                  r_stop_q;

  logic [BITLEN-1:0]     w_x2;
  logic [BITLEN-1:0]     w_y2;
  logic                  w_reject;
  logic                  w_rise;

  mod_double #(.BITLEN(BITLEN)) u_dbl_x (
    .v (r_x),
    .n (r_n),
    .d (w_x2)
  );

  mod_double #(.BITLEN(BITLEN)) u_dbl_y (
    .v (r_y),
    .n (r_n),
    .d (w_y2)
  );

`ifdef MONT_PRECOMP_CHECK_EN
  assign w_reject = ~r_n[0]
                  | (r_n <= BITLEN'(1))
                  | (r_m >= r_n)
                  | (r_e == '0);
`else
  assign w_reject = 1'b0;
`endif

  // A stop level held from an earlier run must not count as completion.
  assign w_rise = bus.exp_stop & ~r_stop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_m      <= '0;
      r_n      <= '0;
      r_e      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_ans    <= '0;
      r_cnt    <= '0;
      r_e_idx  <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_xs     <= 1'b0;
      r_wr     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_stop_q <= 1'b0;
    end else begin
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_xs     <= 1'b0;
      r_wr     <= 1'b0;
      r_stop_q <= bus.exp_stop;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_m     <= bus.m;
            r_n     <= bus.n;
            r_e     <= bus.e;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_reject) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_e_idx <= LOG_BITLEN'(msb_idx(MSB_W'(r_e)));
            r_x     <= BITLEN'(1);
            r_y     <= r_m;
            r_cnt   <= '0;
            r_state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          r_x   <= w_x2;
          r_y   <= w_y2;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= ST_WR_X;
        end
        ST_WR_X: begin
          r_wr    <= 1'b1;
          r_waddr <= ABITS'(ADDR_XBAR);
          r_wdata <= DBITS'(r_x);
          r_state <= ST_WR_M;
        end
        ST_WR_M: begin
          r_wr    <= 1'b1;
          r_waddr <= ABITS'(ADDR_MBAR);
          r_wdata <= DBITS'(r_y);
          r_state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          r_xs    <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_rise) begin
            r_ans   <= bus.exp_ans;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.ans        = r_ans;
  assign bus.exp_start  = r_xs;
  assign bus.exp_e      = r_e;
  assign bus.exp_n      = r_n;
  assign bus.exp_e_idx  = r_e_idx;
  assign bus.pc_wr_en   = r_wr;
  assign bus.pc_wr_addr = r_waddr;
  assign bus.pc_wr_data = r_wdata;

endmodule
